// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and widths for the data-memory port arbiter.
package dmem_arb_pkg;

    localparam int LAT_W  = 4;
    localparam int WAIT_W = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

    // Forces every memory field to zero whenever no access is being issued.
    function automatic mem_req_t mask_req(input mem_req_t req, input logic en);
        mem_req_t res;
        if (en) begin
            res = req;
        end else begin
            res = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_age_ctr.sv
// Saturating DBG starvation counter: clears on a DBG grant, counts lost cycles.
module dmem_arb_age_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Next count: clear wins over increment; increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the MEM stage (CPU) and the
// debug loader (DBG); sequences issue, fixed read latency and response.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic [3:0]  cpu_be_i,
    output logic        cpu_gnt_o,
    output logic        cpu_rvalid_o,
    output logic        cpu_adv_o,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic [3:0]  dbg_be_i,
    output logic        dbg_gnt_o,
    output logic        dbg_rvalid_o,
    output logic [31:0] rdata_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i
);

    arb_state_e        state_q, state_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    req_id_e           owner_q, owner_d;

    mem_req_t cpu_fields_s, dbg_fields_s, win_fields_s;
    logic     issue_s, win_dbg_s, cpu_rv_s, dbg_rv_s, dbg_limit_s, en_s;

    assign cpu_fields_s = {cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_be_i};
    assign dbg_fields_s = {dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_be_i};

    // Next-state, arbitration and response decode.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        owner_d   = owner_q;
        issue_s   = 1'b0;
        win_dbg_s = 1'b0;
        cpu_rv_s  = 1'b0;
        dbg_rv_s  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (cpu_req_i || dbg_req_i) begin
                    issue_s   = 1'b1;
                    win_dbg_s = dbg_req_i && (!cpu_req_i || dbg_limit_s);
                    if (!(win_dbg_s ? dbg_we_i : cpu_we_i)) begin
                        state_d   = ARB_WAIT;
                        lat_cnt_d = LAT_W'(MEM_LAT - 1);
                        owner_d   = win_dbg_s ? REQ_DBG : REQ_CPU;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_WAIT: begin
                if (lat_cnt_q == '0) begin
                    cpu_rv_s = (owner_q == REQ_CPU);
                    dbg_rv_s = (owner_q == REQ_DBG);
                    state_d  = ARB_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, latency counter and load owner registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            lat_cnt_q <= '0;
            owner_q   <= REQ_CPU;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            owner_q   <= owner_d;
        end
    end

    dmem_arb_age_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age_ctr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (dbg_req_i & ~dbg_gnt_o),
        .clr_i      (dbg_gnt_o),
        .at_limit_o (dbg_limit_s)
    );

    // Reset gating keeps the port quiet even if a requester is already asserting.
    assign en_s         = issue_s & ~rst_i;
    assign win_fields_s = win_dbg_s ? dbg_fields_s : cpu_fields_s;
    assign {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} = mask_req(win_fields_s, en_s);
    assign mem_en_o     = en_s;
    assign cpu_gnt_o    = en_s & ~win_dbg_s;
    assign dbg_gnt_o    = en_s & win_dbg_s;
    assign cpu_rvalid_o = cpu_rv_s & ~rst_i;
    assign dbg_rvalid_o = dbg_rv_s & ~rst_i;
    assign rdata_o      = mem_rdata_i;
    assign cpu_adv_o    = rst_i | ~cpu_req_i | (cpu_gnt_o & cpu_we_i) | cpu_rvalid_o;

endmodule
